sddr_cmd_monitor: RTL and testbench
===================================

Name: sddr_cmd_monitor

Overview:
- Device-side decoder for the DDR3 command bus driven by the controller (CS/RAS/CAS/WE, BA, A, CKE).
- Decodes each command, tracks per-bank open/closed state and open row, and times tRCD/tRP/tRFC/tMRD.
- Captures mode-register writes and raises sticky protocol-violation flags.
- Sits on the PHY side of the controller as a bring-up checker and simulation responder; emits one registered event per decoded command.

Parameters:
- BANK_BITS, 3, bank address width; 2**BANK_BITS banks.
- ROW_BITS, 13, address bus width; also the row address width.
- COL_BITS, 10, column bits taken from A[COL_BITS-1:0]; A10 is excluded when COL_BITS>10.
- T_RCD, 5, minimum cycles from ACT to RD/WR, same bank.
- T_RP, 5, minimum cycles from PRE to ACT, same bank.
- T_RFC, 44, cycles after REF during which only NOP/DESEL is legal.
- T_MRD, 4, cycles after MRS during which only NOP/DESEL is legal.

Ports:
- ddr_clock_i  in  1  command bus clock.
- ddr_reset_n_i  in  1  asynchronous active-low reset.
- ddr3_cke_i  in  1  clock enable.
- ddr3_cs_n_i, ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i  in  1 each  command strobes.
- ddr3_ba_i  in  BANK_BITS  bank address.
- ddr3_addr_i  in  ROW_BITS  address bus.
- violation_clear_i  in  1  clears all sticky violation bits.
- evt_valid_o  out  1  one-cycle pulse per decoded command.
- evt_cmd_o  out  3  decoded command: 0 ACT, 1 RD, 2 WR, 3 PRE, 4 PREA, 5 REF, 6 MRS, 7 ZQ.
- evt_bank_o  out  BANK_BITS  bank of the command.
- evt_row_o  out  ROW_BITS  ACT: row; RD/WR: open row of the bank; otherwise raw address.
- evt_col_o  out  COL_BITS  column for RD/WR; 0 otherwise.
- bank_open_o  out  2**BANK_BITS  per-bank open flag.
- mode_reg_o  out  4*ROW_BITS  MR0..MR3 at slices [i*ROW_BITS +: ROW_BITS].
- violation_o  out  8  sticky violation flags.

Behaviour:
- Reset (asynchronous): all outputs 0; all banks CLOSED; all timers 0; device state INIT.
- Decode {cs_n,ras_n,cas_n,we_n}:
  - cs_n=1: DESEL.
  - 0111 NOP, 0011 ACT, 0101 RD, 0100 WR, 0110 ZQ, 0001 REF, 0000 MRS.
  - 0010 PRE; A10=1 makes it PREA.
- Sampling:
  - Command is sampled on each rising edge only when ddr3_cke_i=1; CKE low forces DESEL.
  - Device state leaves INIT on the first sampled cycle with CKE high. Commands are not decoded in INIT.
- Event latency: evt_* registered, 1 cycle after the sampling edge. NOP/DESEL produce no event.
- Device FSM:
  - IDLE -> REFRESHING on REF; timer loads T_RFC-1 and decrements to 0, then IDLE.
  - IDLE -> MRS_WAIT on MRS; timer loads T_MRD-1 and decrements to 0, then IDLE.
  - Any non-NOP command while REFRESHING sets bit 4; while MRS_WAIT sets bit 5. The command is still decoded and applied.
- Per-bank FSM:
  - CLOSED --ACT--> OPEN; row latched, tRCD timer loads T_RCD-1.
  - OPEN --PRE (same bank) or PREA--> CLOSED; tRP timer loads T_RP-1.
  - PRE/PREA to an already CLOSED bank is legal and does not reload tRP.
  - Timers decrement to 0 and saturate there.
- MRS: mode_reg[ba[1:0]] <= addr; upper BA bits ignored.
- Violation bits, set on the sampling edge that decodes the offending command:
  - 0: ACT to an OPEN bank. Row is not overwritten.
  - 1: RD/WR to a CLOSED bank.
  - 2: RD/WR with the bank's tRCD timer nonzero.
  - 3: ACT with the bank's tRP timer nonzero. The bank still opens.
  - 4: command during tRFC.
  - 5: command during tMRD.
  - 6: REF with any bank OPEN.
  - 7: MRS with any bank OPEN.
- Several bits may set in the same cycle.
- violation_clear_i clears all bits on the next edge. If a violation and the clear occur in the same cycle, the violation bit ends up set.
- Event outputs are not affected by violations.

Optional Feature:
- SDDR_AUTO_PRECHARGE_EN defined:
  - RD/WR with A10=1 decodes as auto-precharge. The event still reports RD/WR.
  - The bank goes to CLOSED on the same edge and its tRP timer loads T_RP-1.
- Undefined: A10 is ignored on RD/WR and the bank stays OPEN.

Test Plan:
- CKE low, ACT issued -> no event, bank_open_o=0. Raise CKE, ACT ba=2 row=0x1ABC -> next cycle evt_cmd_o=0, evt_row_o=0x1ABC, bank_open_o=0x04.
- ACT ba=1 row=0x0010, RD ba=1 col=0x040 five cycles later -> evt_cmd_o=1, evt_row_o=0x0010, evt_col_o=0x040, violation_o=0. RD after only 2 cycles -> violation_o[2]=1.
- Banks 0 and 3 open, PREA -> bank_open_o=0. ACT bank 0 on the next cycle -> violation_o[3]=1. Pulse violation_clear_i -> violation_o=0.
- REF with all banks closed, then ACT 10 cycles later -> violation_o[4]=1. Same ACT 44 cycles after REF -> no violation.
- MRS ba=1 addr=0x0044 -> mode_reg_o[2*ROW_BITS-1:ROW_BITS]=0x0044. MRS issued with bank 5 open -> violation_o[7]=1.
- With SDDR_AUTO_PRECHARGE_EN: WR ba=0 addr=0x0400 -> bank 0 closes. Without the macro -> bank 0 stays open.

Source files
------------

// File: rtl/sddr_cmd_monitor.sv
// DDR3 command-bus monitor: decodes commands, tracks bank state and timing, captures MRs, flags violations.
// Optional feature macro SDDR_AUTO_PRECHARGE_EN: RD/WR with A10=1 also precharges the bank.
module sddr_cmd_monitor #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int COL_BITS  = 10,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RFC     = 44,
  parameter int T_MRD     = 4
) (
  input  logic                    ddr_clock_i,
  input  logic                    ddr_reset_n_i,
  input  logic                    ddr3_cke_i,
  input  logic                    ddr3_cs_n_i,
  input  logic                    ddr3_ras_n_i,
  input  logic                    ddr3_cas_n_i,
  input  logic                    ddr3_we_n_i,
  input  logic [BANK_BITS-1:0]    ddr3_ba_i,
  input  logic [ROW_BITS-1:0]     ddr3_addr_i,
  input  logic                    violation_clear_i,
  output logic                    evt_valid_o,
  output logic [2:0]              evt_cmd_o,
  output logic [BANK_BITS-1:0]    evt_bank_o,
  output logic [ROW_BITS-1:0]     evt_row_o,
  output logic [COL_BITS-1:0]     evt_col_o,
  output logic [2**BANK_BITS-1:0] bank_open_o,
  output logic [4*ROW_BITS-1:0]   mode_reg_o,
  output logic [7:0]              violation_o
);

  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam int DEV_MAX   = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int BANK_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int DEV_TW    = $clog2(DEV_MAX + 1);
  localparam int BANK_TW   = $clog2(BANK_MAX + 1);

  localparam logic [DEV_TW-1:0]  RFC_LOAD = DEV_TW'(T_RFC - 1);
  localparam logic [DEV_TW-1:0]  MRD_LOAD = DEV_TW'(T_MRD - 1);
  localparam logic [BANK_TW-1:0] RCD_LOAD = BANK_TW'(T_RCD - 1);
  localparam logic [BANK_TW-1:0] RP_LOAD  = BANK_TW'(T_RP - 1);

  typedef enum logic [2:0] {
    CMD_ACT  = 3'd0,
    CMD_RD   = 3'd1,
    CMD_WR   = 3'd2,
    CMD_PRE  = 3'd3,
    CMD_PREA = 3'd4,
    CMD_REF  = 3'd5,
    CMD_MRS  = 3'd6,
    CMD_ZQ   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    DEV_INIT,
    DEV_IDLE,
    DEV_REFRESHING,
    DEV_MRS_WAIT
  } dev_state_e;

  dev_state_e             dev_state, dev_state_next;
  logic [DEV_TW-1:0]      dev_timer, dev_timer_next;

  logic                   cmd_valid;
  cmd_e                   cmd;
  logic [COL_BITS-1:0]    cmd_col;
  logic                   auto_pre;

  logic [NUM_BANKS-1:0]   bank_open, bank_open_next;
  logic [ROW_BITS-1:0]    bank_row      [NUM_BANKS];
  logic [ROW_BITS-1:0]    bank_row_next [NUM_BANKS];
  logic [BANK_TW-1:0]     trcd          [NUM_BANKS];
  logic [BANK_TW-1:0]     trcd_next     [NUM_BANKS];
  logic [BANK_TW-1:0]     trp           [NUM_BANKS];
  logic [BANK_TW-1:0]     trp_next      [NUM_BANKS];

  logic [7:0]             viol_new;
  logic [7:0]             violation;
  logic [3:0][ROW_BITS-1:0] mode_reg;

`ifdef SDDR_AUTO_PRECHARGE_EN
  assign auto_pre = ddr3_addr_i[10];
`else
  assign auto_pre = 1'b0;
`endif

  // A10 is the auto-precharge pin, so wide columns skip over it.
  generate
    if (COL_BITS > 10) begin : g_col_wide
      assign cmd_col = {ddr3_addr_i[COL_BITS:11], ddr3_addr_i[9:0]};
    end else begin : g_col_narrow
      assign cmd_col = ddr3_addr_i[COL_BITS-1:0];
    end
  endgenerate

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = CMD_ACT;
    if (ddr3_cke_i && (dev_state != DEV_INIT) && !ddr3_cs_n_i) begin
      case ({ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i})
        3'b011: begin cmd_valid = 1'b1; cmd = CMD_ACT; end
        3'b101: begin cmd_valid = 1'b1; cmd = CMD_RD;  end
        3'b100: begin cmd_valid = 1'b1; cmd = CMD_WR;  end
        3'b110: begin cmd_valid = 1'b1; cmd = CMD_ZQ;  end
        3'b001: begin cmd_valid = 1'b1; cmd = CMD_REF; end
        3'b000: begin cmd_valid = 1'b1; cmd = CMD_MRS; end
        3'b010: begin
          cmd_valid = 1'b1;
          cmd       = ddr3_addr_i[10] ? CMD_PREA : CMD_PRE;
        end
        default: cmd_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      dev_state <= DEV_INIT;
      dev_timer <= '0;
    end else begin
      dev_state <= dev_state_next;
      dev_timer <= dev_timer_next;
    end
  end

  // The busy window ends on the edge where the timer would reach zero.
  always_comb begin
    dev_state_next = dev_state;
    dev_timer_next = dev_timer;
    case (dev_state)
      DEV_INIT: begin
        if (ddr3_cke_i) dev_state_next = DEV_IDLE;
      end
      DEV_IDLE: begin
        if (cmd_valid && (cmd == CMD_REF)) begin
          dev_state_next = DEV_REFRESHING;
          dev_timer_next = RFC_LOAD;
        end else if (cmd_valid && (cmd == CMD_MRS)) begin
          dev_state_next = DEV_MRS_WAIT;
          dev_timer_next = MRD_LOAD;
        end
      end
      default: begin
        if (dev_timer <= DEV_TW'(1)) begin
          dev_state_next = DEV_IDLE;
          dev_timer_next = '0;
        end else begin
          dev_timer_next = dev_timer - DEV_TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    bank_open_next = bank_open;
    bank_row_next  = bank_row;
    trcd_next      = trcd;
    trp_next       = trp;
    viol_new       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (|trcd[b]) trcd_next[b] = trcd[b] - BANK_TW'(1);
      if (|trp[b])  trp_next[b]  = trp[b] - BANK_TW'(1);
    end
    if (cmd_valid) begin
      case (cmd)
        CMD_ACT: begin
          if (bank_open[ddr3_ba_i]) begin
            viol_new[0] = 1'b1;
          end else begin
            bank_open_next[ddr3_ba_i] = 1'b1;
            bank_row_next[ddr3_ba_i]  = ddr3_addr_i;
            trcd_next[ddr3_ba_i]      = RCD_LOAD;
          end
          if (|trp[ddr3_ba_i]) viol_new[3] = 1'b1;
        end
        CMD_RD, CMD_WR: begin
          if (!bank_open[ddr3_ba_i]) viol_new[1] = 1'b1;
          if (|trcd[ddr3_ba_i])      viol_new[2] = 1'b1;
          if (auto_pre && bank_open[ddr3_ba_i]) begin
            bank_open_next[ddr3_ba_i] = 1'b0;
            trp_next[ddr3_ba_i]       = RP_LOAD;
          end
        end
        CMD_PRE: begin
          if (bank_open[ddr3_ba_i]) begin
            bank_open_next[ddr3_ba_i] = 1'b0;
            trp_next[ddr3_ba_i]       = RP_LOAD;
          end
        end
        CMD_PREA: begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_open[b]) begin
              bank_open_next[b] = 1'b0;
              trp_next[b]       = RP_LOAD;
            end
          end
        end
        CMD_REF: if (|bank_open) viol_new[6] = 1'b1;
        CMD_MRS: if (|bank_open) viol_new[7] = 1'b1;
        default: viol_new = '0;
      endcase
      if (dev_state == DEV_REFRESHING) viol_new[4] = 1'b1;
      if (dev_state == DEV_MRS_WAIT)   viol_new[5] = 1'b1;
    end
  end

  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      bank_open <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_row[b] <= '0;
        trcd[b]     <= '0;
        trp[b]      <= '0;
      end
    end else begin
      bank_open <= bank_open_next;
      bank_row  <= bank_row_next;
      trcd      <= trcd_next;
      trp       <= trp_next;
    end
  end

  // A violation raised on the clearing edge wins over the clear.
  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      violation <= '0;
      mode_reg  <= '0;
    end else begin
      violation <= (violation_clear_i ? 8'h00 : violation) | viol_new;
      if (cmd_valid && (cmd == CMD_MRS)) mode_reg[ddr3_ba_i[1:0]] <= ddr3_addr_i;
    end
  end

  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      evt_valid_o <= 1'b0;
      evt_cmd_o   <= '0;
      evt_bank_o  <= '0;
      evt_row_o   <= '0;
      evt_col_o   <= '0;
    end else begin
      evt_valid_o <= cmd_valid;
      if (cmd_valid) begin
        evt_cmd_o  <= cmd;
        evt_bank_o <= ddr3_ba_i;
        case (cmd)
          CMD_RD, CMD_WR: begin
            evt_row_o <= bank_row[ddr3_ba_i];
            evt_col_o <= cmd_col;
          end
          default: begin
            evt_row_o <= ddr3_addr_i;
            evt_col_o <= '0;
          end
        endcase
      end
    end
  end

  assign bank_open_o = bank_open;
  assign mode_reg_o  = mode_reg;
  assign violation_o = violation;

endmodule

// File: tb/tb_sddr_cmd_monitor.sv
// Bench for sddr_cmd_monitor: directed steps then random commands, checked against a timestamp-based model.
module tb_sddr_cmd_monitor;

  localparam int BANK_BITS = 3;
  localparam int ROW_BITS  = 13;
  localparam int COL_BITS  = 10;
  localparam int T_RCD     = 5;
  localparam int T_RP      = 5;
  localparam int T_RFC     = 44;
  localparam int T_MRD     = 4;
  localparam int NUM_BANKS = 8;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_RD    = 4'b0101;
  localparam logic [3:0] C_WR    = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;
  localparam logic [3:0] C_ZQ    = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [12:0] addr;
  logic        clr;

  logic        evt_valid;
  logic [2:0]  evt_cmd;
  logic [2:0]  evt_bank;
  logic [12:0] evt_row;
  logic [9:0]  evt_col;
  logic [7:0]  bank_open;
  logic [51:0] mode_reg;
  logic [7:0]  violation;

  int checks = 0;
  int errors = 0;

  bit          m_init;
  bit          m_open    [NUM_BANKS];
  logic [12:0] m_row     [NUM_BANKS];
  int          m_act_t   [NUM_BANKS];
  int          m_pre_t   [NUM_BANKS];
  int          m_busy_until;
  bit          m_busy_ref;
  logic [12:0] m_mr      [4];
  logic [7:0]  m_viol;
  int          now;

  bit          e_valid;
  logic [2:0]  e_cmd;
  logic [2:0]  e_bank;
  logic [12:0] e_row;
  logic [9:0]  e_col;

  sddr_cmd_monitor #(
    .BANK_BITS(BANK_BITS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD)
  ) dut (
    .ddr_clock_i       (clk),
    .ddr_reset_n_i     (rst_n),
    .ddr3_cke_i        (cke),
    .ddr3_cs_n_i       (cs_n),
    .ddr3_ras_n_i      (ras_n),
    .ddr3_cas_n_i      (cas_n),
    .ddr3_we_n_i       (we_n),
    .ddr3_ba_i         (ba),
    .ddr3_addr_i       (addr),
    .violation_clear_i (clr),
    .evt_valid_o       (evt_valid),
    .evt_cmd_o         (evt_cmd),
    .evt_bank_o        (evt_bank),
    .evt_row_o         (evt_row),
    .evt_col_o         (evt_col),
    .bank_open_o       (bank_open),
    .mode_reg_o        (mode_reg),
    .violation_o       (violation)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_init       = 1'b1;
    m_busy_until = 0;
    m_busy_ref   = 1'b0;
    m_viol       = '0;
    now          = 0;
    e_valid      = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      m_open[b]  = 1'b0;
      m_row[b]   = '0;
      m_act_t[b] = -1000;
      m_pre_t[b] = -1000;
    end
    for (int i = 0; i < 4; i++) m_mr[i] = '0;
  endtask

  // Timing rules are kept as timestamps of the last ACT/close per bank and an absolute end of the busy window.
  task automatic modelStep(input logic a_cke, input logic [3:0] a_cmd, input logic [2:0] a_ba,
                           input logic [12:0] a_addr, input logic a_clr);
    int         mc;
    bit         any_open;
    logic [7:0] nv;
    mc = -1;
    nv = '0;
    if (a_cke) begin
      if (m_init) m_init = 1'b0;
      else if (!a_cmd[3]) begin
        case (a_cmd[2:0])
          3'b011:  mc = 0;
          3'b101:  mc = 1;
          3'b100:  mc = 2;
          3'b010:  mc = a_addr[10] ? 4 : 3;
          3'b001:  mc = 5;
          3'b000:  mc = 6;
          3'b110:  mc = 7;
          default: mc = -1;
        endcase
      end
    end
    e_valid = (mc >= 0);
    if (mc >= 0) begin
      any_open = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) any_open |= m_open[b];
      if (now < m_busy_until) nv[m_busy_ref ? 4 : 5] = 1'b1;
      e_cmd  = 3'(mc);
      e_bank = a_ba;
      e_row  = a_addr;
      e_col  = '0;
      case (mc)
        0: begin
          if (m_open[a_ba]) nv[0] = 1'b1;
          else begin
            m_open[a_ba]  = 1'b1;
            m_row[a_ba]   = a_addr;
            m_act_t[a_ba] = now;
          end
          if (now - m_pre_t[a_ba] < T_RP) nv[3] = 1'b1;
        end
        1, 2: begin
          if (!m_open[a_ba]) nv[1] = 1'b1;
          if (now - m_act_t[a_ba] < T_RCD) nv[2] = 1'b1;
          e_row = m_row[a_ba];
          e_col = a_addr[9:0];
`ifdef SDDR_AUTO_PRECHARGE_EN
          if (a_addr[10] && m_open[a_ba]) begin
            m_open[a_ba]  = 1'b0;
            m_pre_t[a_ba] = now;
          end
`endif
        end
        3: if (m_open[a_ba]) begin
          m_open[a_ba]  = 1'b0;
          m_pre_t[a_ba] = now;
        end
        4: for (int b = 0; b < NUM_BANKS; b++) begin
          if (m_open[b]) begin
            m_open[b]  = 1'b0;
            m_pre_t[b] = now;
          end
        end
        5: begin
          if (any_open) nv[6] = 1'b1;
          if (now >= m_busy_until) begin
            m_busy_until = now + T_RFC;
            m_busy_ref   = 1'b1;
          end
        end
        6: begin
          if (any_open) nv[7] = 1'b1;
          m_mr[a_ba[1:0]] = a_addr;
          if (now >= m_busy_until) begin
            m_busy_until = now + T_MRD;
            m_busy_ref   = 1'b0;
          end
        end
        default: nv = nv;
      endcase
    end
    m_viol = (a_clr ? 8'h00 : m_viol) | nv;
    now++;
  endtask

  task automatic checkOutput();
    logic [7:0]  exp_open;
    logic [51:0] exp_mr;
    for (int b = 0; b < NUM_BANKS; b++) exp_open[b] = m_open[b];
    exp_mr = {m_mr[3], m_mr[2], m_mr[1], m_mr[0]};
    checkValue("evt_valid", 64'(evt_valid), 64'(e_valid));
    if (e_valid) begin
      checkValue("evt_cmd",  64'(evt_cmd),  64'(e_cmd));
      checkValue("evt_bank", 64'(evt_bank), 64'(e_bank));
      checkValue("evt_row",  64'(evt_row),  64'(e_row));
      checkValue("evt_col",  64'(evt_col),  64'(e_col));
    end
    checkValue("bank_open", 64'(bank_open), 64'(exp_open));
    checkValue("mode_reg",  64'(mode_reg),  64'(exp_mr));
    checkValue("violation", 64'(violation), 64'(m_viol));
  endtask

  task automatic applyStimulus(input logic a_cke, input logic [3:0] a_cmd, input logic [2:0] a_ba,
                               input logic [12:0] a_addr, input logic a_clr);
    cke   = a_cke;
    cs_n  = a_cmd[3];
    ras_n = a_cmd[2];
    cas_n = a_cmd[1];
    we_n  = a_cmd[0];
    ba    = a_ba;
    addr  = a_addr;
    clr   = a_clr;
    @(posedge clk);
    modelStep(a_cke, a_cmd, a_ba, a_addr, a_clr);
    #1;
    checkOutput();
  endtask

  task automatic cmdNop(input int n);
    repeat (n) applyStimulus(1'b1, C_NOP, 3'd0, 13'h0000, 1'b0);
  endtask

  task automatic cmdClear();
    applyStimulus(1'b1, C_NOP, 3'd0, 13'h0000, 1'b1);
  endtask

  task automatic cmdAct(input logic [2:0] b, input logic [12:0] r);
    applyStimulus(1'b1, C_ACT, b, r, 1'b0);
  endtask

  task automatic cmdRd(input logic [2:0] b, input logic [12:0] a);
    applyStimulus(1'b1, C_RD, b, a, 1'b0);
  endtask

  task automatic cmdWr(input logic [2:0] b, input logic [12:0] a);
    applyStimulus(1'b1, C_WR, b, a, 1'b0);
  endtask

  task automatic cmdPrea();
    applyStimulus(1'b1, C_PRE, 3'd0, 13'h0400, 1'b0);
  endtask

  task automatic cmdRef();
    applyStimulus(1'b1, C_REF, 3'd0, 13'h0000, 1'b0);
  endtask

  task automatic cmdMrs(input logic [2:0] b, input logic [12:0] a);
    applyStimulus(1'b1, C_MRS, b, a, 1'b0);
  endtask

  initial begin
    int          sel;
    logic [2:0]  rb;
    logic [12:0] ra;
    logic        rc;

    rst_n = 1'b0;
    cke   = 1'b0;
    cs_n  = 1'b1;
    ras_n = 1'b1;
    cas_n = 1'b1;
    we_n  = 1'b1;
    ba    = '0;
    addr  = '0;
    clr   = 1'b0;
    modelReset();
    #22;
    $display("[TB] reset state");
    checkOutput();
    checkValue("reset_evt_cmd", 64'(evt_cmd), 64'd0);
    checkValue("reset_evt_row", 64'(evt_row), 64'd0);
    checkValue("reset_evt_col", 64'(evt_col), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] CKE low then first ACT");
    applyStimulus(1'b0, C_ACT, 3'd2, 13'h1ABC, 1'b0);
    checkValue("cke_low_no_evt", 64'(evt_valid), 64'd0);
    checkValue("cke_low_closed", 64'(bank_open), 64'd0);
    cmdNop(1);
    cmdAct(3'd2, 13'h1ABC);
    checkValue("act_evt_cmd", 64'(evt_cmd), 64'd0);
    checkValue("act_evt_row", 64'(evt_row), 64'h1ABC);
    checkValue("act_bank_open", 64'(bank_open), 64'h04);

    $display("[TB] tRCD");
    cmdAct(3'd1, 13'h0010);
    cmdNop(4);
    cmdRd(3'd1, 13'h0040);
    checkValue("rd_evt_cmd", 64'(evt_cmd), 64'd1);
    checkValue("rd_evt_row", 64'(evt_row), 64'h0010);
    checkValue("rd_evt_col", 64'(evt_col), 64'h040);
    checkValue("rd_no_viol", 64'(violation), 64'h00);
    cmdAct(3'd3, 13'h0222);
    cmdNop(1);
    cmdRd(3'd3, 13'h0001);
    checkValue("rcd_viol", 64'(violation[2]), 64'd1);

    $display("[TB] PREA and tRP");
    cmdClear();
    checkValue("clear_viol", 64'(violation), 64'h00);
    cmdPrea();
    cmdNop(5);
    cmdAct(3'd0, 13'h0011);
    cmdAct(3'd3, 13'h0033);
    cmdPrea();
    checkValue("prea_closed", 64'(bank_open), 64'h00);
    cmdAct(3'd0, 13'h0055);
    checkValue("rp_viol", 64'(violation), 64'h08);
    cmdClear();
    checkValue("clear_rp_viol", 64'(violation), 64'h00);

    $display("[TB] tRFC");
    cmdPrea();
    cmdNop(5);
    cmdRef();
    cmdNop(9);
    cmdAct(3'd4, 13'h0100);
    checkValue("rfc_viol", 64'(violation), 64'h10);
    cmdNop(34);
    cmdClear();
    cmdPrea();
    cmdNop(5);
    cmdRef();
    cmdNop(43);
    cmdAct(3'd4, 13'h0100);
    checkValue("rfc_done_no_viol", 64'(violation), 64'h00);

    $display("[TB] MRS");
    cmdPrea();
    cmdNop(5);
    cmdMrs(3'd1, 13'h0044);
    checkValue("mr1_value", 64'(mode_reg[2*ROW_BITS-1:ROW_BITS]), 64'h0044);
    cmdNop(4);
    cmdAct(3'd5, 13'h0300);
    cmdNop(5);
    cmdMrs(3'd0, 13'h0123);
    checkValue("mrs_open_viol", 64'(violation), 64'h80);

    $display("[TB] RD/WR with A10");
    cmdNop(4);
    cmdClear();
    cmdPrea();
    cmdNop(5);
    cmdAct(3'd0, 13'h0007);
    cmdNop(4);
    cmdWr(3'd0, 13'h0400);
    checkValue("wr_evt_cmd", 64'(evt_cmd), 64'd2);
    checkValue("wr_evt_col", 64'(evt_col), 64'h000);
`ifdef SDDR_AUTO_PRECHARGE_EN
    checkValue("wr_ap_bank0", 64'(bank_open[0]), 64'd0);
`else
    checkValue("wr_ap_bank0", 64'(bank_open[0]), 64'd1);
`endif

    $display("[TB] random commands");
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 19));
      rb  = 3'($urandom);
      ra  = 13'($urandom);
      rc  = ($urandom_range(0, 9) == 0);
      case (sel)
        0, 1, 2, 3, 4: applyStimulus(1'b1, C_NOP, rb, ra, rc);
        5, 6, 7:       applyStimulus(1'b1, C_ACT, rb, ra, rc);
        8, 9:          applyStimulus(1'b1, C_RD,  rb, ra, rc);
        10, 11:        applyStimulus(1'b1, C_WR,  rb, ra, rc);
        12, 13: begin
          ra[10] = 1'b0;
          applyStimulus(1'b1, C_PRE, rb, ra, rc);
        end
        14: begin
          ra[10] = 1'b1;
          applyStimulus(1'b1, C_PRE, rb, ra, rc);
        end
        15:      applyStimulus(1'b1, C_REF, rb, ra, rc);
        16:      applyStimulus(1'b1, C_MRS, rb, ra, rc);
        17:      applyStimulus(1'b1, C_ZQ,  rb, ra, rc);
        18:      applyStimulus(1'b1, {1'b1, 3'($urandom)}, rb, ra, rc);
        default: applyStimulus(1'b0, 4'($urandom), rb, ra, rc);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
